scan_box_timing: RTL and testbench
==================================

// Module: scan_box_timing
// PURPOSE
//  Raster timing generator feeding the three-way region clock divider.
//  Produces the pixel coordinates x/y, sync pulses and the display enable.
//  Holds the active bounding box left/right/top/bottom. Box updates from the
//  control side are committed only at the frame boundary, so the divider never
//  sees a box change mid-frame.
// PARAMETERS
//  H_ACTIVE  1280  visible pixels per line
//  H_FP      110   horizontal front porch (pixels)
//  H_SYNC    40    hsync width (pixels)
//  H_BP      220   horizontal back porch; H_TOTAL = sum of the four = 1650
//  V_ACTIVE  720   visible lines
//  V_FP      5     vertical front porch (lines)
//  V_SYNC    5     vsync width (lines)
//  V_BP      20    vertical back porch; V_TOTAL = 750
//  HS_POL    1     hsync active level
//  VS_POL    1     vsync active level
//  BOX_L/R/T/B  220/1060/210/510  box value driven after reset
// PORTS
//  Clock and reset: clk and rst; one clock; rst is synchronous, active-high.
//  clk          in   1   pixel clock; all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  x            out  11  current column, 0..H_TOTAL-1
//  y            out  10  current line, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync at HS_POL
//  vsync        out  1   vertical sync at VS_POL
//  de           out  1   high when x<H_ACTIVE && y<V_ACTIVE
//  frame_start  out  1   one-cycle pulse when x==0 && y==0
//  box_valid    in   1   new box offered on box_* inputs
//  box_ready    out  1   block can accept a new box
//  box_left_i   in   11
//  box_right_i  in   11
//  box_top_i    in   10
//  box_bottom_i in   10
//  left         out  11  committed box edges, to the divider
//  right        out  11
//  top          out  10
//  bottom       out  10
//  box_err      out  1   one-cycle pulse when an offered box is rejected
// BEHAVIOUR
//  Counters h (11b) and v (10b):
//   - h increments every cycle; at H_TOTAL-1 h wraps to 0 and v increments.
//   - v wraps to 0 when h and v are both at their maximum.
//  Outputs are registered from the counter state, giving 1-cycle latency.
//   - x, y, de, hsync, vsync and frame_start are mutually coherent.
//  hsync is active while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//  vsync is active while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
//   - vsync changes together with the h wrap.
//  Reset values:
//   - counters 0; x=0, y=0; de=0; frame_start=0; box_err=0.
//   - hsync=~HS_POL, vsync=~VS_POL; box_ready=1.
//   - left/right/top/bottom = BOX_L/R/T/B; pending flag cleared.
//  First cycle after rst falls: x=0, y=0, frame_start=1, de=1.
//  Box handshake:
//   - On box_valid && box_ready, the box is checked for left<right &&
//     top<bottom && right<=H_ACTIVE && bottom<=V_ACTIVE.
//   - Pass: the box is captured into pending and box_ready goes low next cycle.
//   - Fail: the box is dropped, box_err pulses next cycle, box_ready stays 1.
//  Commit:
//   - Happens on the cycle where h==H_TOTAL-1 && v==V_TOTAL-1 && pending set.
//   - pending is copied to left..bottom, the flag clears, and box_ready=1
//     next cycle.
//   - The new box is therefore first visible on the frame_start cycle.
//  Simultaneous events:
//   - A capture on the commit cycle is not committed in that cycle; it waits
//     one full frame.
//   - Commit always uses pending as it stood before that cycle.
//  rst mid-frame discards pending, restarts counters and reloads defaults.
//  No arithmetic overflow: counters compare with ==, widths are fixed as above.
// STRUCTURE
//  Shared package scan_pkg holds:
//   - timing defaults H_ACTIVE..V_BP, H_TOTAL, V_TOTAL;
//   - BOX defaults; XW=11, YW=10.
//  One sub-module, box_shadow_reg, contains the handshake, validity check,
//  pending register and commit. Its inputs are clk, rst, commit, box_*.
//  The top level holds the counters, sync/de decode and output registers.
// TESTING
//  1. Free run 2 frames -> x wraps 1649->0; y wraps 749->0.
//     frame_start exactly every 1237500 cycles.
//  2. Check line 0 -> de high for x 0..1279; hsync=HS_POL for x 1390..1429.
//     Check frame -> vsync=VS_POL for y 725..729.
//  3. Mid-frame (y=300), offer box 100/900/50/600 -> box_ready drops.
//     left stays 220 until the frame_start cycle, then reads 100/900/50/600.
//  4. Offer left=500, right=400 -> box_err pulses once; box_ready stays 1;
//     outputs are unchanged at the next frame.
//  5. Offer a box on the h=1649, v=749 cycle -> not applied at that frame;
//     applied one frame later.
//  6. Assert rst at y=400 with a box pending -> after release x=y=0;
//     box = 220/1060/210/510; box_ready=1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the raster timing generator and its box shadow register.
// Holds the default 1280x720 timing, the reset-time bounding box, the counter
// widths, the box record type and the box validity check.
package scan_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b1;

  localparam int BOX_L = 220;
  localparam int BOX_R = 1060;
  localparam int BOX_T = 210;
  localparam int BOX_B = 510;

  typedef struct packed {
    logic [XW-1:0] left;
    logic [XW-1:0] right;
    logic [YW-1:0] top;
    logic [YW-1:0] bottom;
  } box_t;

  typedef enum logic {
    BOX_EMPTY = 1'b0,
    BOX_HELD  = 1'b1
  } box_state_t;

  function automatic box_t make_box(input int l, input int r, input int t, input int b);
    box_t bx;
    bx.left   = XW'(l);
    bx.right  = XW'(r);
    bx.top    = YW'(t);
    bx.bottom = YW'(b);
    return bx;
  endfunction

  // A box must be non-empty and fit inside the visible area; the right and
  // bottom edges are exclusive, so they may equal the active size.
  function automatic logic box_ok(input box_t bx, input int h_lim, input int v_lim);
    return (bx.left < bx.right) && (bx.top < bx.bottom) &&
           (bx.right <= XW'(h_lim)) && (bx.bottom <= YW'(v_lim));
  endfunction

endpackage

// File: rtl/scan_box_timing_if.sv
// Bus bundle of the raster timing generator.
//   box_valid, box_*_i   control side offers a new bounding box
//   box_ready, box_err   handshake status (err is a one-cycle reject pulse)
//   x, y, de, hsync, vsync, frame_start   raster position and sync
//   left, right, top, bottom              committed box for the divider
// slave: the timing generator; master: the control side / divider view.
interface scan_box_timing_if;
  import scan_pkg::*;

  logic          box_valid;
  logic          box_ready;
  logic [XW-1:0] box_left_i;
  logic [XW-1:0] box_right_i;
  logic [YW-1:0] box_top_i;
  logic [YW-1:0] box_bottom_i;
  logic          box_err;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          frame_start;

  logic [XW-1:0] left;
  logic [XW-1:0] right;
  logic [YW-1:0] top;
  logic [YW-1:0] bottom;

  modport slave (
    input  box_valid, box_left_i, box_right_i, box_top_i, box_bottom_i,
    output box_ready, box_err,
    output x, y, hsync, vsync, de, frame_start,
    output left, right, top, bottom
  );

  modport master (
    output box_valid, box_left_i, box_right_i, box_top_i, box_bottom_i,
    input  box_ready, box_err,
    input  x, y, hsync, vsync, de, frame_start,
    input  left, right, top, bottom
  );

endinterface

// File: rtl/box_shadow_reg.sv
// Bounding-box shadow register: accepts a box offer, validates it, holds it
// as pending and copies it to the committed box on the frame-boundary strobe.
//   clk, rst        pixel clock, synchronous active-high reset
//   commit          high on the last pixel of the frame
//   box_valid/box_* offered box
//   box_ready       high while nothing is pending
//   box_err         one-cycle pulse after a rejected offer
//   box_q           committed box
//
// state     | meaning
// BOX_EMPTY | no pending box, offers are accepted
// BOX_HELD  | valid box pending, waits for the frame boundary
module box_shadow_reg
  import scan_pkg::*;
#(
  parameter int H_LIM = H_ACTIVE,
  parameter int V_LIM = V_ACTIVE,
  parameter int DEF_L = BOX_L,
  parameter int DEF_R = BOX_R,
  parameter int DEF_T = BOX_T,
  parameter int DEF_B = BOX_B
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit,
  input  logic          box_valid,
  input  logic [XW-1:0] box_left_i,
  input  logic [XW-1:0] box_right_i,
  input  logic [YW-1:0] box_top_i,
  input  logic [YW-1:0] box_bottom_i,
  output logic          box_ready,
  output logic          box_err,
  output box_t          box_q
);

  localparam box_t DEF_BOX = make_box(DEF_L, DEF_R, DEF_T, DEF_B);

  box_state_t state, state_nxt;
  box_t       offered, pending;
  logic       capture, load, err_nxt;

  assign offered   = {box_left_i, box_right_i, box_top_i, box_bottom_i};
  assign box_ready = (state == BOX_EMPTY);

  // A capture can only happen in BOX_EMPTY, so a box accepted on the commit
  // cycle is never committed in that same cycle and waits a full frame.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      BOX_EMPTY: begin
        if (box_valid) begin
          if (box_ok(offered, H_LIM, V_LIM)) begin
            capture   = 1'b1;
            state_nxt = BOX_HELD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      BOX_HELD: begin
        if (commit) begin
          load      = 1'b1;
          state_nxt = BOX_EMPTY;
        end
      end
      default: state_nxt = BOX_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOX_EMPTY;
      pending <= '0;
      box_q   <= DEF_BOX;
      box_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      box_err <= err_nxt;
      if (capture) pending <= offered;
      if (load)    box_q   <= pending;
    end
  end

endmodule

// File: rtl/scan_box_timing.sv
// Raster timing generator for the region clock divider.
//   clk, rst   pixel clock, synchronous active-high reset
//   bus        scan_box_timing_if.slave: box handshake in, raster position,
//              sync, display enable and committed box out
// All outputs are registered from the h/v counter state (one-cycle latency),
// and the committed box goes through the same output stage so a new box
// appears together with frame_start.
module scan_box_timing
  import scan_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP,
  parameter bit HS_LVL  = HS_POL,
  parameter bit VS_LVL  = VS_POL,
  parameter int DEF_L   = BOX_L,
  parameter int DEF_R   = BOX_R,
  parameter int DEF_T   = BOX_T,
  parameter int DEF_B   = BOX_B
) (
  input logic           clk,
  input logic           rst,
  scan_box_timing_if.slave bus
);

  localparam int H_TOT = H_ACT + H_FRONT + H_SW + H_BACK;
  localparam int V_TOT = V_ACT + V_FRONT + V_SW + V_BACK;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOT - 1);
  localparam logic [XW-1:0] H_VIS  = XW'(H_ACT);
  localparam logic [XW-1:0] HS_ON  = XW'(H_ACT + H_FRONT);
  localparam logic [XW-1:0] HS_OFF = XW'(H_ACT + H_FRONT + H_SW);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOT - 1);
  localparam logic [YW-1:0] V_VIS  = YW'(V_ACT);
  localparam logic [YW-1:0] VS_ON  = YW'(V_ACT + V_FRONT);
  localparam logic [YW-1:0] VS_OFF = YW'(V_ACT + V_FRONT + V_SW);

  localparam box_t DEF_BOX = make_box(DEF_L, DEF_R, DEF_T, DEF_B);

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          commit;
  box_t          box_shadow;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          de_q, hs_q, vs_q, fs_q;
  box_t          box_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign commit = (h == H_LAST) && (v == V_LAST);

  box_shadow_reg #(
    .H_LIM (H_ACT),
    .V_LIM (V_ACT),
    .DEF_L (DEF_L),
    .DEF_R (DEF_R),
    .DEF_T (DEF_T),
    .DEF_B (DEF_B)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .commit       (commit),
    .box_valid    (bus.box_valid),
    .box_left_i   (bus.box_left_i),
    .box_right_i  (bus.box_right_i),
    .box_top_i    (bus.box_top_i),
    .box_bottom_i (bus.box_bottom_i),
    .box_ready    (bus.box_ready),
    .box_err      (bus.box_err),
    .box_q        (box_shadow)
  );

  // vsync is decoded from v, which only moves on the h wrap, so it toggles
  // in the same output cycle where x returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_LVL;
      vs_q    <= ~VS_LVL;
      fs_q    <= 1'b0;
      box_out <= DEF_BOX;
    end else begin
      x_q     <= h;
      y_q     <= v;
      de_q    <= (h < H_VIS) && (v < V_VIS);
      hs_q    <= ((h >= HS_ON) && (h < HS_OFF)) ? HS_LVL : ~HS_LVL;
      vs_q    <= ((v >= VS_ON) && (v < VS_OFF)) ? VS_LVL : ~VS_LVL;
      fs_q    <= (h == '0) && (v == '0);
      box_out <= box_shadow;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.frame_start = fs_q;
  assign bus.left        = box_out.left;
  assign bus.right       = box_out.right;
  assign bus.top         = box_out.top;
  assign bus.bottom      = box_out.bottom;

endmodule

// File: tb/tb_scan_box_timing.sv
// Bench for scan_box_timing on a reduced raster (28x17) so several frames fit
// in a short run. Expected raster values come from the cycle index since reset
// release; box offers push their expected commit/reject into queues that the
// negedge monitor drains as the DUT presents frame_start / box_err.
module tb_scan_box_timing;
  import scan_pkg::*;

  localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
  localparam int VA = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int DL = 3, DR = 12, DT = 2, DB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  scan_box_timing_if bus();

  scan_box_timing #(
    .H_ACT(HA), .H_FRONT(HF), .H_SW(HSW), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SW(VSW), .V_BACK(VB),
    .HS_LVL(1'b1), .VS_LVL(1'b1),
    .DEF_L(DL), .DEF_R(DR), .DEF_T(DT), .DEF_B(DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          apply_t;
    logic [63:0] box;
  } commit_t;

  commit_t     box_q[$];
  int          err_q[$];
  int          t_now = -2;
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_from = 1;
  int          busy_until = 0;
  int          last_fs = -1;
  logic [63:0] cur_box;

  function automatic logic [63:0] pack_box(input int l, input int r, input int t, input int b);
    return {22'd0, 11'(l), 11'(r), 10'(t), 10'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t_now, act, req);
    end
  endtask

  // Output cycle index: -1 while reset is sampled, 0 on the first cycle after.
  always @(posedge clk) begin
    if (rst) t_now <= -1;
    else if (t_now >= -1) t_now <= t_now + 1;
  end

  always @(negedge clk) begin
    int ex, ey;
    logic de_e, hs_e, vs_e, fs_e, err_e, rdy_e;
    logic [63:0] dut_box;
    commit_t c;
    dut_box = 64'({bus.left, bus.right, bus.top, bus.bottom});
    if (t_now == -1) begin
      box_q.delete();
      err_q.delete();
      cur_box = pack_box(DL, DR, DT, DB);
      last_fs = -1;
      chk("reset_timing", 64'({bus.x, bus.y, bus.de, bus.hsync, bus.vsync, bus.frame_start}),
          64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
      chk("reset_ready", 64'(bus.box_ready), 64'd1);
      chk("reset_err", 64'(bus.box_err), 64'd0);
      chk("reset_box", dut_box, cur_box);
    end else if (t_now >= 0) begin
      ex   = t_now % HT;
      ey   = (t_now / HT) % VT;
      de_e = (ex < HA) && (ey < VA);
      hs_e = (ex >= HA + HF) && (ex < HA + HF + HSW);
      vs_e = (ey >= VA + VF) && (ey < VA + VF + VSW);
      fs_e = (ex == 0) && (ey == 0);
      chk("timing", 64'({bus.x, bus.y, bus.de, bus.hsync, bus.vsync, bus.frame_start}),
          64'({11'(ex), 10'(ey), de_e, hs_e, vs_e, fs_e}));
      if (bus.frame_start) begin
        if (last_fs >= 0) chk("fs_period", 64'(t_now - last_fs), 64'(FRAME));
        last_fs = t_now;
      end
      if (box_q.size() > 0 && box_q[0].apply_t == t_now) begin
        c = box_q.pop_front();
        cur_box = c.box;
        chk("commit_on_fs", 64'(bus.frame_start), 64'd1);
      end
      chk("box", dut_box, cur_box);
      err_e = (err_q.size() > 0) && (err_q[0] == t_now);
      if (err_e) void'(err_q.pop_front());
      chk("box_err", 64'(bus.box_err), 64'(err_e));
      rdy_e = !((t_now >= busy_from) && (t_now <= busy_until));
      chk("box_ready", 64'(bus.box_ready), 64'(rdy_e));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(input int px, input int py);
    int budget;
    budget = 2 * FRAME + 10;
    while (!(t_now >= 0 && (t_now % HT) == px && ((t_now / HT) % VT) == py) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos timeout actual=none required=x%0d_y%0d", px, py);
    end
  endtask

  // Drives one offer for one cycle and records what the box rules predict.
  task automatic offer(input int l, input int r, input int tp, input int b);
    int t0, tc;
    commit_t c;
    t0 = t_now;
    bus.box_valid    = 1'b1;
    bus.box_left_i   = 11'(l);
    bus.box_right_i  = 11'(r);
    bus.box_top_i    = 10'(tp);
    bus.box_bottom_i = 10'(b);
    if (!((t0 >= busy_from) && (t0 <= busy_until))) begin
      if ((l < r) && (tp < b) && (r <= HA) && (b <= VA)) begin
        tc = t0 + 1;
        while (((tc + 2) % FRAME) != 0) tc++;
        busy_from  = t0 + 1;
        busy_until = tc;
        c.apply_t  = tc + 2;
        c.box      = pack_box(l, r, tp, b);
        box_q.push_back(c);
      end else begin
        err_q.push_back(t0 + 1);
      end
    end
    @(posedge clk);
    #1;
    bus.box_valid = 1'b0;
  endtask

  initial begin
    bus.box_valid    = 1'b0;
    bus.box_left_i   = '0;
    bus.box_right_i  = '0;
    bus.box_top_i    = '0;
    bus.box_bottom_i = '0;
    cycles(3);
    rst = 1'b0;

    cycles(2 * FRAME + 5);

    wait_pos(4, 5);
    offer(1, 16, 0, 10);
    cycles(FRAME + 10);

    wait_pos(7, 3);
    offer(9, 5, 1, 4);
    offer(2, 6, 5, 5);
    offer(0, 17, 0, 9);
    offer(0, 16, 0, 11);
    offer(4, 5, 9, 10);
    cycles(FRAME + 10);

    wait_pos(HT - 2, VT - 1);
    offer(2, 10, 3, 7);
    cycles(2 * FRAME + 10);

    for (int i = 0; i < 40; i++) begin
      cycles(int'($urandom_range(0, 200)));
      offer(int'($urandom_range(0, 18)), int'($urandom_range(0, 18)),
            int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
    end
    cycles(2 * FRAME);

    wait_pos(0, 2);
    offer(5, 9, 1, 3);
    wait_pos(0, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    busy_from  = 1;
    busy_until = 0;
    cycles(2);
    rst = 1'b0;
    cycles(2 * FRAME + 5);

    chk("box_q_drained", 64'(box_q.size()), 64'd0);
    chk("err_q_drained", 64'(err_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
